fft_in_reorder4: RTL
====================

// Module: fft_in_reorder4
// PURPOSE
//  Input formatter ahead of the 4-lane FFT front end. Accepts a serial stream of complex samples x[n],
//  buffers whole N-point frames in a ping-pong memory, and replays each frame 4 samples per cycle:
//  fftIn0_up=x[k], fftIn0_down=x[k+N/2], fftIn1_up=x[k+N/4], fftIn1_down=x[k+3N/4], k=0..N/4-1.
//  Also emits frame alignment (out_sof/out_valid) used to gate the FFT stage's rst.
// PARAMETERS
//  NBITS  10   bits per real/imag part; packed sample = {re,im}, 2*NBITS wide, two's complement
//  N      128  frame length; power of 2, >=8; DEPTH = N/4 words per bank
// PORTS
//  clk           in   1         rising-edge clock
//  rst           in   1         synchronous, active-high reset
//  in_data       in   2*NBITS   serial sample x[n], {re[2*NBITS-1:NBITS], im[NBITS-1:0]}
//  in_valid      in   1         in_data valid this cycle
//  in_ready      out  1         block accepts in_data this cycle (transfer = in_valid & in_ready)
//  fftIn0_up     out  2*NBITS   lane x[k]
//  fftIn0_down   out  2*NBITS   lane x[k+N/2]
//  fftIn1_up     out  2*NBITS   lane x[k+N/4]
//  fftIn1_down   out  2*NBITS   lane x[k+3N/4]
//  out_valid     out  1         the four lanes carry frame data
//  out_sof       out  1         one-cycle pulse with k=0 of each frame
// BEHAVIOUR
//  - Reset: in_ready=0 during rst, 1 the cycle after rst deasserts; all lane outputs=0, out_valid=0,
//    out_sof=0; both pages empty; write ptr n=0, write page=0, read page=0; partial frame discarded.
//  - Memory: 4 banks (b=n[log2N-1:log2N-2]), each 2*DEPTH words (page*DEPTH + n[log2N-3:0]).
//    Synchronous write; synchronous read, registered output.
//  - Write side: on transfer, store at (bank b, page wp, addr n); n increments, wraps N-1->0.
//    On the transfer of n=N-1: full[wp]<=1, wp toggles. in_ready = !full[wp] (combinational).
//    in_valid while in_ready=0 is ignored, no state change.
//  - Read FSM: IDLE -> READ when full[rp]=1; READ issues addr k=0..DEPTH-1 on all 4 banks, one per cycle,
//    back-to-back. After issuing k=DEPTH-1: full[rp]<=0, rp toggles; if full[new rp] already 1 go
//    straight to READ with k=0 (no bubble), else IDLE.
//  - Latency: out_valid/lane data appear 1 cycle after address k is issued; out_sof with k=0.
//    First sample of a frame to out_sof: >= 2 cycles after the n=N-1 write (write-then-read, no bypass).
//  - Lane outputs forced to 0 whenever out_valid=0; no arithmetic, data passes bit-exact.
//  - Simultaneous: write completion setting full[x] and read completion clearing full[y], x!=y, both
//    take effect same cycle. Same page cannot be both written and read (guaranteed by flags).
//  - Throughput: sustained 1 sample/cycle input never stalls (read takes N/4 < N cycles per frame).
//  - rst mid-frame or mid-read: all flags cleared, output burst aborted next cycle (out_valid=0).
// TESTING
//  1 rst, then N=128 samples x[n]={n,-n} back-to-back -> in_ready stays 1; 32 out_valid cycles,
//    cycle k: in0_up={k,-k}, in0_down={k+64,..}, in1_up={k+32,..}, in1_down={k+96,..}; out_sof at k=0 only.
//  2 three frames continuous, values frame*256+n -> three 32-cycle bursts, frame order preserved,
//    in_ready never drops, out_valid=0 and lanes=0 between bursts.
//  3 hold out side: fill both pages by stalling read? (read cannot stall) -> instead drive in_valid
//    with random gaps (50%) -> identical output ordering to scenario 1, no lost/duplicated samples.
//  4 frame completes on same cycle previous read finishes -> no overlap, next out_sof exactly 2 cycles
//    after last write, flags consistent.
//  5 rst asserted at n=70 of a frame and at k=10 of a burst -> out_valid=0 cycle after rst, in_ready=0
//    during rst; next full frame after rst reproduces scenario 1 exactly.
//  6 extreme values {2^(NBITS-1)-1, -2^(NBITS-1)} on all positions -> lanes bit-exact, no sign change.

Source files
------------

// File: rtl/fft_in_reorder4.sv
// Serial-to-4-lane input formatter for the FFT front end: buffers whole frames in a
// ping-pong memory of 4 banks and replays x[k], x[k+N/2], x[k+N/4], x[k+3N/4] per cycle.
module fft_in_reorder4 #(
  parameter int NBITS = 10,
  parameter int N     = 128
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [2*NBITS-1:0] in_data,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [2*NBITS-1:0] fftIn0_up,
  output logic [2*NBITS-1:0] fftIn0_down,
  output logic [2*NBITS-1:0] fftIn1_up,
  output logic [2*NBITS-1:0] fftIn1_down,
  output logic               out_valid,
  output logic               out_sof
);
  localparam int W     = 2 * NBITS;
  localparam int LOGN  = $clog2(N);
  localparam int DEPTH = N / 4;
  localparam int AW    = LOGN - 2;

  typedef enum logic {S_IDLE, S_READ} state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   rd_k_q, rd_k_d;
  logic [LOGN-1:0] wr_n_q, wr_n_d;
  logic            wp_q, wp_d;
  logic            rp_q, rp_d;
  logic [1:0]      full_q, full_d;
  logic            vld_p1_q, vld_p1_d;
  logic            sof_p1_q, sof_p1_d;

  logic            rd_issue;
  logic            rd_last;
  logic            wr_en;
  logic [1:0]      wr_bank;
  logic [AW:0]     wr_addr;
  logic [AW:0]     rd_addr;

  logic [W-1:0]    mem_q [4][2*DEPTH];
  logic [W-1:0]    rd_data_p1_q [4];

  // Reset forces in_ready low combinationally so nothing is accepted while rst is held.
  assign in_ready = !rst && !full_q[wp_q];
  assign wr_en    = in_valid && in_ready;
  assign wr_bank  = wr_n_q[LOGN-1 -: 2];
  assign wr_addr  = {wp_q, wr_n_q[AW-1:0]};
  assign rd_addr  = {rp_q, rd_k_q};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      rd_k_q   <= '0;
      wr_n_q   <= '0;
      wp_q     <= 1'b0;
      rp_q     <= 1'b0;
      full_q   <= '0;
      vld_p1_q <= 1'b0;
      sof_p1_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      rd_k_q   <= rd_k_d;
      wr_n_q   <= wr_n_d;
      wp_q     <= wp_d;
      rp_q     <= rp_d;
      full_q   <= full_d;
      vld_p1_q <= vld_p1_d;
      sof_p1_q <= sof_p1_d;
    end
  end

  always_comb begin
    state_d = state_q;
    rd_k_d  = rd_k_q;
    case (state_q)
      S_IDLE: begin
        if (full_q[rp_q]) begin
          state_d = S_READ;
          rd_k_d  = '0;
        end
      end
      S_READ: begin
        rd_k_d = rd_k_q + 1'b1;
        // Chain straight into the other page when it is already waiting: no bubble.
        if (rd_k_q == AW'(DEPTH - 1)) begin
          state_d = full_q[~rp_q] ? S_READ : S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    rd_issue = (state_q == S_READ);
    rd_last  = rd_issue && (rd_k_q == AW'(DEPTH - 1));
    vld_p1_d = rd_issue;
    sof_p1_d = rd_issue && (rd_k_q == '0);
  end

  // Writer and reader always own different pages, so set and clear never hit the same flag.
  always_comb begin
    wr_n_d = wr_n_q;
    wp_d   = wp_q;
    rp_d   = rp_q;
    full_d = full_q;
    if (wr_en) begin
      wr_n_d = wr_n_q + 1'b1;
      if (wr_n_q == LOGN'(N - 1)) begin
        full_d[wp_q] = 1'b1;
        wp_d         = ~wp_q;
      end
    end
    if (rd_last) begin
      full_d[rp_q] = 1'b0;
      rp_d         = ~rp_q;
    end
  end

  // Stage p0 -> p1: bank write and registered bank read.
  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (wr_en && (wr_bank == 2'(b))) begin
        mem_q[b][wr_addr] <= in_data;
      end
      rd_data_p1_q[b] <= mem_q[b][rd_addr];
    end
  end

  // Bank 0 holds x[0..N/4-1], bank 1 x[N/4..], bank 2 x[N/2..], bank 3 x[3N/4..].
  assign out_valid   = vld_p1_q;
  assign out_sof     = sof_p1_q;
  assign fftIn0_up   = vld_p1_q ? rd_data_p1_q[0] : '0;
  assign fftIn1_up   = vld_p1_q ? rd_data_p1_q[1] : '0;
  assign fftIn0_down = vld_p1_q ? rd_data_p1_q[2] : '0;
  assign fftIn1_down = vld_p1_q ? rd_data_p1_q[3] : '0;

endmodule
